// File: rtl/rv32i_memarb_pkg.sv
// Shared types and constants for the RV32I unified memory arbiter.
package rv32i_memarb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2,
        StResp  = 2'd3
    } state_e;

    // d_wsize encodings
    localparam logic [1:0] WS_LOAD = 2'b00;
    localparam logic [1:0] WS_BYTE = 2'b01;
    localparam logic [1:0] WS_HALF = 2'b10;
    localparam logic [1:0] WS_WORD = 2'b11;

    // Port select values (also the round-robin "last granted" encoding)
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/rv32i_memarb_lanes.sv
// Byte-enable / store-lane generation and misalignment detection for the data port.
module rv32i_memarb_lanes
    import rv32i_memarb_pkg::*;
(
    input  logic [1:0]  i_wsize,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_we,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    // Decode access size into enables, replicated lanes and alignment fault.
    always_comb begin
        o_we       = (i_wsize != WS_LOAD);
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_wsize)
            WS_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            WS_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            WS_WORD: begin
                o_misalign = |i_addr_lo;
            end
            default: ;  // loads are raw aligned words and never fault
        endcase
    end

endmodule

// File: rtl/rv32i_memarb.sv
// Unified fetch/data memory arbiter for a single-ported von Neumann memory.
// Optional feature: define MEMARB_RR_EN for round-robin tie breaking;
// otherwise the data port always wins ties.
module rv32i_memarb
    import rv32i_memarb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_d_req,
    input  logic [1:0]        i_d_wsize,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_valid,
    output logic              o_d_err,
    output logic              o_stall_if,
    output logic              o_stall_d,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_e            r_state, w_state_d;
    logic              r_mem_req, r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
    logic              r_if_valid, r_d_valid, r_d_err;

    logic              w_grant, w_grant_port, w_accept;
    logic              w_lane_we, w_misalign;
    logic [3:0]        w_lane_be;
    logic [DATA_W-1:0] w_lane_wdata;
    logic [ADDR_W-1:0] w_if_waddr, w_d_waddr;
    logic              w_tie_port;
    logic              w_unused_if_lo;

    // Fetch low address bits are architecturally zero and deliberately ignored.
    assign w_unused_if_lo = ^i_if_addr[1:0];
    assign w_if_waddr     = {i_if_addr[ADDR_W-1:2], 2'b00};
    assign w_d_waddr      = {i_d_addr[ADDR_W-1:2], 2'b00};

    rv32i_memarb_lanes u_lanes (
        .i_wsize    (i_d_wsize),
        .i_addr_lo  (i_d_addr[1:0]),
        .i_wdata    (i_d_wdata),
        .o_we       (w_lane_we),
        .o_be       (w_lane_be),
        .o_wdata    (w_lane_wdata),
        .o_misalign (w_misalign)
    );

`ifdef MEMARB_RR_EN
    logic r_rr_last;

    // The port that did not win last time takes the next tie.
    assign w_tie_port = (r_rr_last == PORT_IF) ? PORT_D : PORT_IF;

    // Remember the most recently granted port; reset favours fetch first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_last <= PORT_D;
        end else if (w_grant) begin
            r_rr_last <= w_grant_port;
        end
    end
`else
    // Fixed priority: the M-stage access is older, so data wins ties.
    assign w_tie_port = PORT_D;
`endif

    // Next-state logic with grant and memory-accept decode.
    always_comb begin
        w_state_d    = r_state;
        w_grant      = 1'b0;
        w_grant_port = PORT_IF;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_if_req || i_d_req) begin
                    w_grant = 1'b1;
                    if (i_if_req && i_d_req) begin
                        w_grant_port = w_tie_port;
                    end else begin
                        w_grant_port = i_d_req ? PORT_D : PORT_IF;
                    end
                    if (w_grant_port == PORT_D) begin
                        w_state_d = w_misalign ? StResp : StBusyD;
                    end else begin
                        w_state_d = StBusyI;
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (i_mem_ready) begin
                    w_accept  = 1'b1;
                    w_state_d = StResp;
                end
            end
            StResp: begin
                // Requests are not sampled here so a finished req cannot re-issue.
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Memory request registers, read-data capture and one-cycle valid pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            if (w_grant) begin
                if (w_grant_port == PORT_D) begin
                    if (w_misalign) begin
                        // Fault completes without touching memory.
                        r_d_valid <= 1'b1;
                        r_d_err   <= 1'b1;
                        r_d_rdata <= '0;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_lane_we;
                        r_mem_be    <= w_lane_be;
                        r_mem_addr  <= w_d_waddr;
                        r_mem_wdata <= w_lane_wdata;
                    end
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= 4'b1111;
                    r_mem_addr  <= w_if_waddr;
                    r_mem_wdata <= '0;
                end
            end
            if (w_accept) begin
                r_mem_req <= 1'b0;
                if (r_state == StBusyI) begin
                    r_if_rdata <= i_mem_rdata;
                    r_if_valid <= 1'b1;
                end else begin
                    r_d_rdata <= i_mem_rdata;
                    r_d_valid <= 1'b1;
                end
            end
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = r_d_valid;
    assign o_d_err     = r_d_err;
    assign o_stall_if  = i_if_req & ~r_if_valid;
    assign o_stall_d   = i_d_req & ~r_d_valid;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_rv32i_memarb.sv
// Self-checking bench for rv32i_memarb: directed scenarios plus randomized data
// traffic checked against a byte-array reference memory.
module tb_rv32i_memarb;

    localparam logic [1:0] WS_LOAD = 2'b00;
    localparam logic [1:0] WS_BYTE = 2'b01;
    localparam logic [1:0] WS_HALF = 2'b10;
    localparam logic [1:0] WS_WORD = 2'b11;

    logic        clk, rst_n;
    logic        if_req, if_valid, d_req, d_valid, d_err, stall_if, stall_d;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_wsize;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_n  = 0;

    bit [31:0] mem [0:4095];

    rv32i_memarb u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_valid  (if_valid),
        .i_d_req     (d_req),
        .i_d_wsize   (d_wsize),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_rdata   (d_rdata),
        .o_d_valid   (d_valid),
        .o_d_err     (d_err),
        .o_stall_if  (stall_if),
        .o_stall_d   (stall_d),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: ready after wait_n cycles of held request; junk read data otherwise.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                cnt++;
                if (cnt > wait_n) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem[mem_addr[13:2]];
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                cnt       = 0;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results of the last transaction
    int          r_lat;
    logic [31:0] r_rd, r_maddr, r_mwd;
    logic        r_err, r_seen, r_stable, r_stall_ok, r_mwe;
    logic [3:0]  r_be;

    task automatic d_txn(input logic [1:0] ws, input logic [31:0] a, input logic [31:0] wd);
        logic [40:0] snap;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_wsize = ws; d_addr = a; d_wdata = wd;
        r_lat = -1; r_seen = 1'b0; r_stable = 1'b1; r_stall_ok = 1'b1;
        r_rd = 'x; r_err = 1'bx; snap = '0;
        for (int c = 0; c < 60 && r_lat < 0; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!r_seen) begin
                    r_seen = 1'b1;
                    snap = {mem_we, mem_be, mem_addr};
                    r_mwe = mem_we; r_be = mem_be; r_maddr = mem_addr; r_mwd = mem_wdata;
                end else if ({mem_we, mem_be, mem_addr} !== snap || mem_wdata !== r_mwd) begin
                    r_stable = 1'b0;
                end
            end
            if (stall_d !== !d_valid) r_stall_ok = 1'b0;
            if (d_valid) begin
                r_lat = c; r_rd = d_rdata; r_err = d_err;
            end
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic f_txn(input logic [31:0] a);
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = a;
        r_lat = -1; r_seen = 1'b0; r_stall_ok = 1'b1; r_rd = 'x;
        for (int c = 0; c < 60 && r_lat < 0; c++) begin
            @(negedge clk);
            if (mem_req && !r_seen) begin
                r_seen = 1'b1; r_maddr = mem_addr; r_mwe = mem_we;
                check("fetch_mem_req_cycle", c, 1);
            end
            if (stall_if !== !if_valid) r_stall_ok = 1'b0;
            if (if_valid) begin
                r_lat = c; r_rd = if_rdata;
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    initial begin
        int          i_lat, d_lat;
        logic [7:0]  refm [0:63];
        logic        vflag;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wsize = WS_LOAD; d_addr = '0; d_wdata = '0;
        mem[32'h100 >> 2] = 32'h0050_0093;
        mem[32'h200 >> 2] = 32'h0000_0013;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {if_rdata | d_rdata}, 0);
        check("rst_valids", {if_valid, d_valid, d_err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Simultaneous requests straight after reset
        wait_n = 0;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_wsize = WS_WORD; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
        i_lat = -1; d_lat = -1;
        for (int c = 0; c < 40 && (i_lat < 0 || d_lat < 0); c++) begin
            @(negedge clk);
            if (if_valid && i_lat < 0) begin
                i_lat = c;
                check("tie_if_rdata", if_rdata, 32'h0000_0013);
            end
            if (d_valid && d_lat < 0) d_lat = c;
            @(posedge clk);
            #1;
            if (i_lat >= 0) if_req = 1'b0;
            if (d_lat >= 0) d_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEMARB_RR_EN
        check("tie_if_lat", i_lat, 2);
        check("tie_d_lat", d_lat, 5);
`else
        check("tie_d_lat", d_lat, 2);
        check("tie_if_lat", i_lat, 5);
`endif
        check("tie_store_word", mem[32'h1000 >> 2], 32'hDEAD_BEEF);

        // Fetch only
        f_txn(32'h100);
        check("fetch_lat", r_lat, 2);
        check("fetch_rdata", r_rd, 32'h0050_0093);
        check("fetch_addr", r_maddr, 32'h100);
        check("fetch_we", r_mwe, 0);
        check("fetch_stall", r_stall_ok, 1);

        // Store byte into the top lane
        d_txn(WS_BYTE, 32'h1003, 32'h0000_00AB);
        check("sb_lat", r_lat, 2);
        check("sb_be", r_be, 4'b1000);
        check("sb_wdata", r_mwd, 32'hABAB_ABAB);
        check("sb_addr", r_maddr, 32'h1000);
        check("sb_we", r_mwe, 1);
        check("sb_err", r_err, 0);

        // Misaligned store half
        d_txn(WS_HALF, 32'h1001, 32'h0000_1234);
        check("mis_lat", r_lat, 1);
        check("mis_err", r_err, 1);
        check("mis_rdata", r_rd, 0);
        check("mis_no_mem_req", r_seen, 0);
        check("mis_stall", r_stall_ok, 1);

        // Load with three wait cycles
        wait_n = 3;
        d_txn(WS_LOAD, 32'h1002, 32'h0);
        check("ld_lat", r_lat, 5);
        check("ld_rdata", r_rd, 32'hABAD_BEEF);
        check("ld_stable", r_stable, 1);
        check("ld_stall", r_stall_ok, 1);
        check("ld_addr", r_maddr, 32'h1000);
        check("ld_be", r_be, 4'b1111);
        check("ld_we", r_mwe, 0);

        // Reset while the data access is outstanding
        wait_n = 20;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_wsize = WS_LOAD; d_addr = 32'h1004;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_busy_req", mem_req, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_req", mem_req, 0);
        d_req = 1'b0;
        vflag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_valid) vflag = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_valid) vflag = 1'b1;
        end
        check("rstmid_no_valid", vflag, 0);
        f_txn(32'h100);
        check("rstmid_fetch_lat", r_lat, 2);
        check("rstmid_fetch_rdata", r_rd, 32'h0050_0093);

        // Randomized data traffic against a byte-addressed reference
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v;
            v = $urandom;
            mem[(32'h2000 >> 2) + w] = v;
            for (int b = 0; b < 4; b++) refm[4*w + b] = v[8*b +: 8];
        end
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  ws;
            logic [5:0]  off;
            logic [31:0] wd, a, expw;
            logic        mis;
            int          wn;
            ws  = 2'($urandom_range(0, 3));
            off = 6'($urandom_range(0, 63));
            wd  = $urandom;
            wn  = $urandom_range(0, 2);
            a   = 32'h2000 + 32'(off);
            mis = (ws == WS_HALF && off[0]) || (ws == WS_WORD && off[1:0] != 2'b00);
            wait_n = wn;
            d_txn(ws, a, wd);
            check($sformatf("rnd%0d_lat", n), r_lat, mis ? 1 : 2 + wn);
            check($sformatf("rnd%0d_err", n), r_err, mis);
            if (mis) begin
                check($sformatf("rnd%0d_rdata0", n), r_rd, 0);
            end else if (ws == WS_LOAD) begin
                expw = {refm[{off[5:2], 2'd3}], refm[{off[5:2], 2'd2}],
                        refm[{off[5:2], 2'd1}], refm[{off[5:2], 2'd0}]};
                check($sformatf("rnd%0d_load", n), r_rd, expw);
            end else begin
                refm[off] = wd[7:0];
                if (ws != WS_BYTE) refm[off + 6'd1] = wd[15:8];
                if (ws == WS_WORD) begin
                    refm[off + 6'd2] = wd[23:16];
                    refm[off + 6'd3] = wd[31:24];
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
